lp_multifunc_seq: RTL and testbench

Sequential request/response initiator for a datapath-gated multifunction unit (`DW_lp_multifunc_DG`-class responder). It accepts one operand/function request over a valid/ready channel and drives the unit's `a`, `func` and `DG_ctrl` inputs. It asserts `DG_ctrl` only for the configured result latency, captures `z`/`status`, and returns them over a valid/ready response channel. It sits between a scheduler and the shared function unit, so the unit is gated off whenever no legal operation is in flight.

---
 rtl/lp_multifunc_seq.sv | 122 ++++++++++++
 tb/tb_lp_multifunc_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_multifunc_seq.sv
// Request/response initiator for a datapath-gated multifunction unit.
// Optional build macro LP_MF_SEQ_ZERO_IDLE_EN zeroes mf_a/mf_func outside WAIT.
module lp_multifunc_seq #(
    parameter int OP_WIDTH    = 24,
    parameter int FUNC_SELECT = 127,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_WIDTH:0]   req_a,
    input  logic [15:0]         req_func,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OP_WIDTH+1:0] rsp_z,
    output logic                rsp_status,
    output logic                rsp_err,
    output logic [OP_WIDTH:0]   mf_a,
    output logic [15:0]         mf_func,
    output logic                mf_dg_ctrl,
    input  logic [OP_WIDTH+1:0] mf_z,
    input  logic                mf_status
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [15:0] FUNC_MASK = 16'(FUNC_SELECT & 127);
    localparam logic [3:0]  LAT       = 4'(LATENCY);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       one_hot;
    logic       legal;
    logic       last;

    assign one_hot = (req_func != 16'd0) &&
                     ((req_func & (req_func - 16'd1)) == 16'd0);
    assign legal   = one_hot && ((req_func & ~FUNC_MASK) == 16'd0);
    assign last    = (state_q == WAIT) && (cnt_q == 4'd1);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 4'd0;
            mf_a       <= '0;
            mf_func    <= '0;
            mf_dg_ctrl <= 1'b0;
            rsp_z      <= '0;
            rsp_status <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                if (legal) begin
                    mf_a       <= req_a;
                    mf_func    <= req_func;
                    mf_dg_ctrl <= 1'b1;
                    cnt_q      <= LAT;
                end else begin
                    rsp_err    <= 1'b1;
                    rsp_z      <= '0;
                    rsp_status <= 1'b0;
                end
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Result is valid only while the unit is still enabled.
            if (last) begin
                rsp_z      <= mf_z;
                rsp_status <= mf_status;
                rsp_err    <= 1'b0;
                mf_dg_ctrl <= 1'b0;
`ifdef LP_MF_SEQ_ZERO_IDLE_EN
                mf_a       <= '0;
                mf_func    <= '0;
`else
                mf_a       <= mf_a;
                mf_func    <= mf_func;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lp_multifunc_seq.sv
// Randomized and directed bench for lp_multifunc_seq, three latencies.
// Honors LP_MF_SEQ_ZERO_IDLE_EN when checking idle unit inputs.
module tb_lp_multifunc_seq;

    localparam int OPW = 24;
    localparam int NI  = 3;
    localparam int LATS [NI] = '{2, 1, 15};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid  [NI];
    logic            req_ready  [NI];
    logic [OPW:0]    req_a      [NI];
    logic [15:0]     req_func   [NI];
    logic            rsp_valid  [NI];
    logic            rsp_ready  [NI];
    logic [OPW+1:0]  rsp_z      [NI];
    logic            rsp_status [NI];
    logic            rsp_err    [NI];
    logic [OPW:0]    mf_a       [NI];
    logic [15:0]     mf_func    [NI];
    logic            mf_dg      [NI];
    logic [OPW+1:0]  mf_z       [NI];
    logic            mf_status  [NI];

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        // Unit model: only meaningful while gated on.
        assign mf_z[g]      = mf_dg[g] ? {1'b0, mf_a[g]} + 1'b1 : 'x;
        assign mf_status[g] = mf_dg[g] ? mf_a[g][0] : 1'bx;

        lp_multifunc_seq #(
            .OP_WIDTH   (OPW),
            .FUNC_SELECT(127),
            .LATENCY    (LATS[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_a     (req_a[g]),
            .req_func  (req_func[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_z     (rsp_z[g]),
            .rsp_status(rsp_status[g]),
            .rsp_err   (rsp_err[g]),
            .mf_a      (mf_a[g]),
            .mf_func   (mf_func[g]),
            .mf_dg_ctrl(mf_dg[g]),
            .mf_z      (mf_z[g]),
            .mf_status (mf_status[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] idle_v(logic [63:0] v);
`ifdef LP_MF_SEQ_ZERO_IDLE_EN
        return 64'd0 & v;
`else
        return v;
`endif
    endfunction

    // Issue one request; return at the first cycle with rsp_valid.
    task automatic xact(input int i, input logic [OPW:0] a,
                        input logic [15:0] f, output int k_rsp,
                        output int dg_n, output logic [OPW:0] a1,
                        output logic [15:0] f1);
        int w = 0;
        k_rsp = 0;
        dg_n  = 0;
        a1    = '0;
        f1    = '0;
        req_a[i]     = a;
        req_func[i]  = f;
        req_valid[i] = 1'b1;
        while (!req_ready[i] && w < 40) begin
            tick();
            w++;
        end
        chk("req_ready", 64'(req_ready[i]), 64'd1);
        tick();
        req_valid[i] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                a1 = mf_a[i];
                f1 = mf_func[i];
            end
            if (mf_dg[i]) dg_n++;
            if (rsp_valid[i]) begin
                k_rsp = k;
                break;
            end
            tick();
        end
    endtask

    task automatic rand_b2b(input int i, input int n);
        logic [OPW:0]   a;
        logic [15:0]    f;
        logic [OPW+1:0] ez;
        logic           es;
        int             prev = 0;
        int             w;
        rsp_ready[i] = 1'b1;
        a = 25'($urandom);
        f = 16'd1 << $urandom_range(6, 0);
        req_a[i]     = a;
        req_func[i]  = f;
        req_valid[i] = 1'b1;
        for (int t = 0; t < n; t++) begin
            w = 0;
            while (!req_ready[i] && w < 40) begin
                tick();
                w++;
            end
            chk("b2b_ready", 64'(req_ready[i]), 64'd1);
            if (t > 0) chk("b2b_space", 64'(cyc - prev), 64'(LATS[i] + 2));
            prev = cyc;
            tick();
            ez = {1'b0, a} + 26'd1;
            es = a[0];
            a = 25'($urandom);
            f = 16'd1 << $urandom_range(6, 0);
            req_a[i]    = a;
            req_func[i] = f;
            if (t == n - 1) req_valid[i] = 1'b0;
            w = 0;
            while (!rsp_valid[i] && w < 40) begin
                tick();
                w++;
            end
            chk("b2b_valid", 64'(rsp_valid[i]), 64'd1);
            chk("b2b_z", 64'(rsp_z[i]), 64'(ez));
            chk("b2b_st", 64'(rsp_status[i]), 64'(es));
            chk("b2b_err", 64'(rsp_err[i]), 64'd0);
        end
        tick();
    endtask

    initial begin
        int              k;
        int              d;
        int              seen;
        int              w;
        logic [OPW:0]    a1;
        logic [15:0]     f1;
        logic [OPW+1:0]  z0;
        logic            s0;
        logic            e0;
        logic [15:0]     bad [2];
        bad[0] = 16'h0003;
        bad[1] = 16'h0080;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_a[i]     = '0;
            req_func[i]  = '0;
            rsp_ready[i] = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_dg", 64'(mf_dg[0]), 64'd0);
        chk("rst_mfa", 64'(mf_a[0]), 64'd0);
        chk("rst_mff", 64'(mf_func[0]), 64'd0);
        chk("rst_z", 64'(rsp_z[0]), 64'd0);
        chk("rst_err", 64'(rsp_err[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        xact(0, 25'h10, 16'h0001, k, d, a1, f1);
        chk("lg_lat", 64'(k), 64'd3);
        chk("lg_dg", 64'(d), 64'd2);
        chk("lg_mfa", 64'(a1), 64'h10);
        chk("lg_mff", 64'(f1), 64'h1);
        chk("lg_z", 64'(rsp_z[0]), 64'h11);
        chk("lg_st", 64'(rsp_status[0]), 64'd0);
        chk("lg_err", 64'(rsp_err[0]), 64'd0);
        chk("resp_mfa", 64'(mf_a[0]), idle_v(64'h10));
        tick();
        chk("hs_valid", 64'(rsp_valid[0]), 64'd0);
        chk("idle_mfa", 64'(mf_a[0]), idle_v(64'h10));
        chk("idle_mff", 64'(mf_func[0]), idle_v(64'h1));

        for (int b = 0; b < 2; b++) begin
            xact(0, 25'h1234, bad[b], k, d, a1, f1);
            chk("il_lat", 64'(k), 64'd1);
            chk("il_dg", 64'(d), 64'd0);
            chk("il_err", 64'(rsp_err[0]), 64'd1);
            chk("il_z", 64'(rsp_z[0]), 64'd0);
            chk("il_st", 64'(rsp_status[0]), 64'd0);
            chk("il_mfa", 64'(mf_a[0]), idle_v(64'h10));
            tick();
        end

        rsp_ready[0] = 1'b0;
        xact(0, 25'h0abc1, 16'h0040, k, d, a1, f1);
        z0 = rsp_z[0];
        s0 = rsp_status[0];
        e0 = rsp_err[0];
        chk("bp_z", 64'(z0), 64'h0abc2);
        chk("bp_st", 64'(s0), 64'd1);
        req_a[0]     = 25'h55;
        req_func[0]  = 16'h0002;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp_zs", 64'(rsp_z[0]), 64'(z0));
            chk("bp_sts", 64'(rsp_status[0]), 64'(s0));
            chk("bp_errs", 64'(rsp_err[0]), 64'(e0));
            chk("bp_rdy", 64'(req_ready[0]), 64'd0);
        end
        rsp_ready[0] = 1'b1;
        tick();
        chk("bp_rdy_hs", 64'(req_ready[0]), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("bp_acc", 64'(mf_dg[0]), 64'd1);
        chk("bp_mfa", 64'(mf_a[0]), 64'h55);
        w = 0;
        while (!rsp_valid[0] && w < 40) begin
            tick();
            w++;
        end
        chk("bp2_z", 64'(rsp_z[0]), 64'h56);
        tick();

        req_a[0]     = 25'h33;
        req_func[0]  = 16'h0004;
        req_valid[0] = 1'b1;
        chk("ab_rdy", 64'(req_ready[0]), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("ab_wait", 64'(mf_dg[0]), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("ab_dg", 64'(mf_dg[0]), 64'd0);
        chk("ab_valid", 64'(rsp_valid[0]), 64'd0);
        chk("ab_mfa", 64'(mf_a[0]), 64'd0);
        chk("ab_mff", 64'(mf_func[0]), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid[0]) seen++;
        end
        chk("ab_norsp", 64'(seen), 64'd0);

        for (int i = 0; i < NI; i++) begin
            rand_b2b(i, 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
